// File: rtl/vram_map_pkg.sv
// vram_map_pkg: VRAM address map, default word counts and arbiter FSM encoding
package vram_map_pkg;
    localparam logic [11:0] V32_BASE = 12'h000;
    localparam logic [11:0] V8_BASE = 12'h800;
    localparam int SEL_BIT = 11;
    localparam int V32_WORDS_DEF = 1152;
    localparam int V8_WORDS_DEF = 1792;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    function automatic logic in_range(input logic [11:0] a, input int v32_words, input int v8_words);
        return a[SEL_BIT] ? int'(a[10:0]) < v8_words : int'(a[10:0]) < v32_words;
    endfunction
endpackage

// File: rtl/vram_bus_arbiter_arb2.sv
// arb2: two-master grant select; round-robin with rr_last when VRAM_ARB_RR_EN is defined, else req0 priority
module arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic g
);
`ifdef VRAM_ARB_RR_EN
    logic rr_last;
    assign g = req0 && req1 ? !rr_last : req1;
    always_ff @(posedge clk)
        if (reset) rr_last <= 1'b1;
        else if (take) rr_last <= g;
`else
    logic unused;
    assign unused = clk ^ reset ^ take;
    assign g = !req0 && req1;
`endif
endmodule

// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: shares VRAM32/VRAM8 CPU ports between two masters via a 4-state access FSM
// Build option: VRAM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module vram_bus_arbiter
    import vram_map_pkg::*;
#(
    parameter int V32_WORDS = V32_WORDS_DEF,
    parameter int V8_WORDS = V8_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [11:0] r0_addr,
    input  logic [31:0] r0_d,
    output logic [31:0] r0_q,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [11:0] r1_addr,
    input  logic [31:0] r1_d,
    output logic [31:0] r1_q,
    output logic        r1_ack,
    output logic [10:0] vram32_addr,
    output logic [31:0] vram32_d,
    output logic        vram32_we,
    input  logic [31:0] vram32_q,
    output logic [10:0] vram8_addr,
    output logic [7:0]  vram8_d,
    output logic        vram8_we,
    input  logic [7:0]  vram8_q
);
    logic [1:0] state;
    logic take, g, gnt, lat_sel, lat_ok, req_we, ok;
    logic [11:0] req_addr;
    logic [31:0] req_d, rdata;
    assign take = state == ST_IDLE && (r0_req || r1_req);
    arb2 u_arb2 (.clk(clk), .reset(reset), .req0(r0_req), .req1(r1_req), .take(take), .g(g));
    assign req_addr = g ? r1_addr : r0_addr;
    assign req_we = g ? r1_we : r0_we;
    assign req_d = g ? r1_d : r0_d;
    assign ok = in_range(req_addr, V32_WORDS, V8_WORDS);
    assign rdata = !lat_ok ? '0 : lat_sel ? {24'b0, vram8_q} : vram32_q;
    // RAM ports are registered on the IDLE edge so they are valid throughout ACCESS and held afterwards
    always_ff @(posedge clk)
        if (reset) begin
            state <= ST_IDLE;
            gnt <= 1'b0;
            lat_sel <= 1'b0;
            lat_ok <= 1'b0;
            r0_q <= '0;
            r1_q <= '0;
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            vram32_addr <= '0;
            vram32_d <= '0;
            vram32_we <= 1'b0;
            vram8_addr <= '0;
            vram8_d <= '0;
            vram8_we <= 1'b0;
        end else begin
            state <= take || state != ST_IDLE ? state + 2'd1 : state;
            vram32_we <= 1'b0;
            vram8_we <= 1'b0;
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            if (take) begin
                gnt <= g;
                lat_sel <= req_addr[SEL_BIT];
                lat_ok <= ok;
                if (req_addr[SEL_BIT]) begin
                    vram8_addr <= req_addr[10:0];
                    vram8_d <= req_d[7:0];
                    vram8_we <= req_we && ok;
                end else begin
                    vram32_addr <= req_addr[10:0];
                    vram32_d <= req_d;
                    vram32_we <= req_we && ok;
                end
            end
            if (state == ST_WAIT) begin
                if (gnt) begin
                    r1_q <= rdata;
                    r1_ack <= 1'b1;
                end else begin
                    r0_q <= rdata;
                    r0_ack <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb_vram_bus_arbiter: randomized and directed bench against a transaction-level scheduling/memory model
module tb_vram_bus_arbiter;
    import vram_map_pkg::*;
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] d;
    } op_t;
`ifdef VRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_clr = 1'b1;
    logic r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [11:0] r0_addr = 0, r1_addr = 0;
    logic [31:0] r0_d = 0, r1_d = 0, r0_q, r1_q;
    logic r0_ack, r1_ack, vram32_we, vram8_we;
    logic [10:0] vram32_addr, vram8_addr;
    logic [31:0] vram32_d, vram32_q;
    logic [7:0] vram8_d, vram8_q;
    always #5 clk = ~clk;

    vram_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_d(r0_d), .r0_q(r0_q), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_d(r1_d), .r1_q(r1_q), .r1_ack(r1_ack),
        .vram32_addr(vram32_addr), .vram32_d(vram32_d), .vram32_we(vram32_we), .vram32_q(vram32_q),
        .vram8_addr(vram8_addr), .vram8_d(vram8_d), .vram8_we(vram8_we), .vram8_q(vram8_q)
    );

    // Synchronous-read RAMs; contents are stored XOR a per-address seed so unwritten words are not zero
    logic [31:0] m32 [0:2047];
    logic [7:0]  m8  [0:2047];
    function automatic logic [31:0] seed32(input logic [10:0] a);
        return {21'b0, a} * 32'h9E3779B9 + 32'd1;
    endfunction
    function automatic logic [7:0] seed8(input logic [10:0] a);
        return 8'({21'b0, a} * 32'd37 + 32'd5);
    endfunction
    always @(posedge clk)
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) begin
                m32[i] <= '0;
                m8[i] <= '0;
            end
        end else begin
            if (vram32_we) m32[vram32_addr] <= vram32_d ^ seed32(vram32_addr);
            if (vram8_we) m8[vram8_addr] <= vram8_d ^ seed8(vram8_addr);
            vram32_q <= m32[vram32_addr] ^ seed32(vram32_addr);
            vram8_q <= m8[vram8_addr] ^ seed8(vram8_addr);
        end

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] sh32 [0:2047];
    logic [7:0]  sh8  [0:2047];
    op_t q0[$], q1[$];
    logic [1:0] req = 2'b00;
    bit inflight[2] = '{0, 0};
    int due[2] = '{-1, -1};
    int gap[2] = '{0, 0};
    bit exp_rd[2] = '{0, 0};
    logic [31:0] exp_q[2] = '{0, 0};
    int next_idle = 0, hold_rst = 3;
    bit rr_last = 1'b1, rst_pending = 1'b0, force_b2b = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int m);
        return m != 0 ? q1.size() : q0.size();
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int k = $urandom_range(0, 5);
        o.we = 1'($urandom_range(0, 1));
        o.d = $urandom;
        o.addr = k < 2 ? 12'($urandom_range(0, 7)) :
                 k < 4 ? 12'h800 + 12'($urandom_range(0, 7)) :
                 k == 4 ? ($urandom_range(0, 1) != 0 ? 12'h47F : 12'($urandom_range(12'h480, 12'h7FF))) :
                 ($urandom_range(0, 1) != 0 ? 12'hEFF : 12'($urandom_range(12'hF00, 12'hFFF)));
        return o;
    endfunction

    // One clock: drive masters, advance the transaction model, sample after the edge, retire acks
    task automatic step();
        op_t f[2], op;
        bit g, sel, ok, gnt_now;
        logic [10:0] off;
        logic e32, e8;
        reset = hold_rst > 0 || (rst_pending && (due[0] == cyc || due[1] == cyc));
        if (hold_rst > 0) hold_rst--;
        if (reset && hold_rst == 0) rst_pending = 1'b0;
        for (int m = 0; m < 2; m++)
            if (!req[m] && qsize(m) > 0) begin
                if (gap[m] > 0) gap[m]--;
                else req[m] = 1'b1;
            end
        f[0] = q0.size() > 0 ? q0[0] : '0;
        f[1] = q1.size() > 0 ? q1[0] : '0;
        r0_req = req[0];
        r1_req = req[1];
        r0_we = inflight[0] ? 1'($urandom) : f[0].we;
        r1_we = inflight[1] ? 1'($urandom) : f[1].we;
        r0_addr = inflight[0] ? 12'($urandom) : f[0].addr;
        r1_addr = inflight[1] ? 12'($urandom) : f[1].addr;
        r0_d = inflight[0] ? $urandom : f[0].d;
        r1_d = inflight[1] ? $urandom : f[1].d;
        e32 = 1'b0;
        e8 = 1'b0;
        gnt_now = 1'b0;
        sel = 1'b0;
        off = '0;
        op = '0;
        if (reset) begin
            due = '{-1, -1};
            inflight = '{0, 0};
            exp_q = '{0, 0};
            next_idle = cyc + 1;
            rr_last = 1'b1;
        end else if (cyc >= next_idle && req != 2'b00) begin
            g = req == 2'b11 ? (RR_EN ? !rr_last : 1'b0) : req[1];
            rr_last = g;
            op = f[g];
            gnt_now = 1'b1;
            inflight[g] = 1'b1;
            due[g] = cyc + 2;
            next_idle = cyc + 4;
            sel = op.addr[11];
            off = op.addr[10:0];
            ok = sel ? int'(off) < 1792 : int'(off) < 1152;
            if (op.we && ok) begin
                if (sel) sh8[off] = op.d[7:0];
                else sh32[off] = op.d;
                e8 = sel;
                e32 = !sel;
            end
            exp_rd[g] = !op.we;
            exp_q[g] = !ok ? 32'h0 : sel ? {24'b0, sh8[off]} : sh32[off];
        end
        @(posedge clk);
        @(negedge clk);
        ram_clr = 1'b0;
        if (reset) begin
            check("rst_q", {r0_q, r1_q}, 64'h0);
            check("rst_ctl", {r0_ack, r1_ack, vram32_we, vram8_we, vram32_addr, vram8_addr, vram8_d}, 64'h0);
            check("rst_d32", {32'h0, vram32_d}, 64'h0);
        end else begin
            check("ack0", {63'h0, r0_ack}, {63'h0, due[0] == cyc});
            check("ack1", {63'h0, r1_ack}, {63'h0, due[1] == cyc});
            check("we32", {63'h0, vram32_we}, {63'h0, e32});
            check("we8", {63'h0, vram8_we}, {63'h0, e8});
            if (gnt_now) begin
                check(sel ? "addr8" : "addr32", {53'h0, sel ? vram8_addr : vram32_addr}, {53'h0, off});
                if (op.we) check(sel ? "d8" : "d32", {32'h0, sel ? {24'h0, vram8_d} : vram32_d},
                                 {32'h0, sel ? {24'h0, op.d[7:0]} : op.d});
            end
            if (due[0] == cyc && exp_rd[0]) check("q0", {32'h0, r0_q}, {32'h0, exp_q[0]});
            if (due[1] == cyc && exp_rd[1]) check("q1", {32'h0, r1_q}, {32'h0, exp_q[1]});
        end
        for (int m = 0; m < 2; m++)
            if (due[m] == cyc) begin
                inflight[m] = 1'b0;
                due[m] = -1;
                if (m != 0) void'(q1.pop_front());
                else void'(q0.pop_front());
                if (qsize(m) == 0 || !(force_b2b || $urandom_range(0, 1) != 0)) begin
                    req[m] = 1'b0;
                    gap[m] = $urandom_range(1, 3);
                end
            end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q0.size() + q1.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", 64'(q0.size() + q1.size()), 64'h0);
        repeat (4) step();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            sh32[i] = seed32(11'(i));
            sh8[i] = seed8(11'(i));
        end
        repeat (4) step();
        q0.push_back('{1'b1, 12'h000, 32'hDEADBEEF});
        q0.push_back('{1'b0, 12'h000, 32'h0});
        drain(40);
        q1.push_back('{1'b1, 12'h805, 32'h123456A5});
        q1.push_back('{1'b0, 12'h805, 32'h0});
        drain(40);
        force_b2b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b0, 12'(i), 32'h0});
            q1.push_back('{1'b0, 12'h800 + 12'(i), 32'h0});
        end
        drain(80);
        force_b2b = 1'b0;
        q0.push_back('{1'b0, 12'h480, 32'h0});
        q0.push_back('{1'b1, 12'h700, 32'h000000FF});
        q0.push_back('{1'b0, 12'h700, 32'h0});
        q0.push_back('{1'b0, 12'h47F, 32'h0});
        q1.push_back('{1'b1, 12'hF00, 32'h000000FF});
        q1.push_back('{1'b0, 12'hF00, 32'h0});
        q1.push_back('{1'b1, 12'hEFF, 32'h0000003C});
        q1.push_back('{1'b0, 12'hEFF, 32'h0});
        drain(120);
        rst_pending = 1'b1;
        q0.push_back('{1'b0, 12'h001, 32'h0});
        q1.push_back('{1'b0, 12'h801, 32'h0});
        drain(60);
        force_b2b = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back('{1'b1, 12'h010 + 12'(i), 32'hA0A0_0000 + 32'(i)});
        drain(60);
        force_b2b = 1'b0;
        for (int i = 0; i < 150; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drain(6000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
